// File: rtl/adc_frame_align_pkg.sv
// adc_frame_align_pkg: shared FSM states, command sub-addresses and error counter width
package adc_frame_align_pkg;
    typedef enum logic [2:0] {ST_SETTLE, ST_SEARCH, ST_VERIFY, ST_LOCKED, ST_MANUAL} state_t;
    localparam logic [7:0] SUB_REALIGN = 8'd0;
    localparam logic [7:0] SUB_MANUAL  = 8'd1;
    localparam logic [7:0] SUB_CLR_ERR = 8'd2;
    localparam int ERR_W = 16;
endpackage

// File: rtl/adc_frame_align_if.sv
// adc_frame_align_if: shared command bus (one-cycle strobe, 16-bit address, 16-bit data)
interface adc_frame_align_if;
    logic        cmd_trig_in;
    logic [15:0] cmd_addr_in;
    logic [15:0] cmd_data_in;
    modport master (output cmd_trig_in, cmd_addr_in, cmd_data_in);
    modport slave  (input  cmd_trig_in, cmd_addr_in, cmd_data_in);
endinterface

// File: rtl/adc_frame_align_lane_window_slip.sv
// adc_frame_align_lane_window_slip: per-lane {prev, cur} window with registered slip select
// ports: raw word in (MSB earliest), slip offset, registered aligned word out
module adc_frame_align_lane_window_slip #(
    parameter int N_SERIAL = 4,
    parameter int SW       = (N_SERIAL > 1) ? $clog2(N_SERIAL) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_SERIAL-1:0] raw,
    input  logic [SW-1:0]       slip,
    output logic [N_SERIAL-1:0] aligned
);
    logic [N_SERIAL-1:0]   prev;
    logic [2*N_SERIAL-1:0] win;

    assign win = {prev, raw};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev    <= '0;
            aligned <= '0;
        end else begin
            prev    <= raw;
            aligned <= win[2*N_SERIAL-1-int'(slip) -: N_SERIAL];
        end
    end
endmodule

// File: rtl/adc_frame_align.sv
// adc_frame_align: frame-lane word aligner, lock supervisor and sample assembler for LVDS ADCs
// ports: clk_in/rst_in, cmd bus (slave), raw lane/frame words in; samples, frame word,
//        valid, lock, sticky sweep failure, slip offset and saturating error count out
module adc_frame_align import adc_frame_align_pkg::*; #(
    parameter int                N_CH          = 2,
    parameter int                LANES_PER_CH  = 4,
    parameter int                N_SERIAL      = 4,
    parameter logic [N_SERIAL-1:0] FR_PATTERN  = 4'b1100,
    parameter logic [7:0]        CMD_ADDR      = 8'h33,
    parameter int                LOCK_COUNT    = 16,
    parameter int                MISS_LIMIT    = 4,
    parameter int                SETTLE_CYCLES = 3,
    localparam int               SAMPLE_BITS   = LANES_PER_CH * N_SERIAL,
    localparam int               N_LANES       = N_CH * LANES_PER_CH,
    localparam int               SW            = (N_SERIAL > 1) ? $clog2(N_SERIAL) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    adc_frame_align_if.slave              cmd,
    input  logic [N_LANES*N_SERIAL-1:0]   lane_data_in,
    input  logic [N_SERIAL-1:0]           frame_data_in,
    output logic [N_CH*SAMPLE_BITS-1:0]   sample_out,
    output logic                          sample_valid_out,
    output logic [N_SERIAL-1:0]           frame_out,
    output logic                          locked_out,
    output logic                          fail_out,
    output logic [SW-1:0]                 slip_out,
    output logic [ERR_W-1:0]              err_count_out
);
    state_t state, state_d;
    logic [SW-1:0] slip;
    logic [15:0] settle_cnt, match_cnt, miss_cnt, sweep_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic fail, fr_match, cmd_ok, settle_done, lock_done, miss_done, slip_step;
    logic [7:0] sub;
    logic [N_SERIAL-1:0] al [N_LANES+1];
    logic [(N_LANES+1)*N_SERIAL-1:0] all_raw;
    logic [N_CH*SAMPLE_BITS-1:0] asm_smp;

    // frame lane rides as the extra top lane so every lane shares one slip
    assign all_raw = {frame_data_in, lane_data_in};

    for (genvar i = 0; i <= N_LANES; i++) begin : g_lane
        adc_frame_align_lane_window_slip #(.N_SERIAL(N_SERIAL), .SW(SW)) u_win (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .raw    (all_raw[i*N_SERIAL +: N_SERIAL]),
            .slip   (slip),
            .aligned(al[i])
        );
    end

    assign cmd_ok      = cmd.cmd_trig_in && cmd.cmd_addr_in[15:8] == CMD_ADDR;
    assign sub         = cmd.cmd_addr_in[7:0];
    assign fr_match    = al[N_LANES] == FR_PATTERN;
    assign settle_done = settle_cnt == 16'(SETTLE_CYCLES - 1);
    assign lock_done   = match_cnt == 16'(LOCK_COUNT - 1);
    assign miss_done   = miss_cnt == 16'(MISS_LIMIT - 1);
    assign slip_step   = (state == ST_SEARCH || state == ST_VERIFY) && !fr_match;

    always_ff @(posedge clk_in) begin
        state <= rst_in ? ST_SETTLE : state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_SETTLE: state_d = settle_done ? ST_SEARCH : ST_SETTLE;
            ST_SEARCH: state_d = !fr_match ? ST_SETTLE : (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
            ST_VERIFY: state_d = !fr_match ? ST_SETTLE : lock_done ? ST_LOCKED : ST_VERIFY;
            ST_LOCKED: state_d = (!fr_match && miss_done) ? ST_SEARCH : ST_LOCKED;
            default:   state_d = state;
        endcase
        if (cmd_ok && sub == SUB_REALIGN) state_d = ST_SETTLE;
        else if (cmd_ok && sub == SUB_MANUAL) state_d = ST_MANUAL;
    end

    always_comb begin
        locked_out    = state == ST_LOCKED;
        slip_out      = slip;
        fail_out      = fail;
        err_count_out = err_cnt;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (cmd_ok && sub == SUB_REALIGN)) begin
            slip       <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            sweep_cnt  <= '0;
            err_cnt    <= '0;
            fail       <= 1'b0;
        end else if (cmd_ok && sub == SUB_MANUAL) begin
            slip       <= SW'(cmd.cmd_data_in % 16'(N_SERIAL));
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            settle_cnt <= (state == ST_SETTLE && !settle_done) ? settle_cnt + 16'd1 : '0;
            match_cnt  <= (state == ST_SEARCH && fr_match) ? 16'd1 :
                          (state == ST_VERIFY && fr_match) ? match_cnt + 16'd1 : '0;
            miss_cnt   <= (state == ST_LOCKED && !fr_match && !miss_done) ? miss_cnt + 16'd1 : '0;
            if (slip_step) slip <= (slip == SW'(N_SERIAL - 1)) ? '0 : slip + SW'(1);
            // sweep count saturates once the failure threshold is reached
            sweep_cnt  <= slip_step ? ((sweep_cnt == 16'(2*N_SERIAL)) ? sweep_cnt : sweep_cnt + 16'd1) :
                          (state_d == ST_LOCKED) ? '0 : sweep_cnt;
            fail       <= fail || (slip_step && sweep_cnt >= 16'(2*N_SERIAL - 1));
            err_cnt    <= (cmd_ok && sub == SUB_CLR_ERR) ? '0 :
                          (state == ST_LOCKED && !fr_match && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
        end
    end

    // time slot k of lane l lands at sample bit SAMPLE_BITS-1-(k*LANES_PER_CH+l)
    always_comb begin
        asm_smp = '0;
        for (int c = 0; c < N_CH; c++)
            for (int l = 0; l < LANES_PER_CH; l++)
                for (int k = 0; k < N_SERIAL; k++)
                    asm_smp[c*SAMPLE_BITS + SAMPLE_BITS-1-(k*LANES_PER_CH+l)] = al[c*LANES_PER_CH+l][N_SERIAL-1-k];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out       <= '0;
            frame_out        <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_out       <= asm_smp;
            frame_out        <= al[N_LANES];
            sample_valid_out <= state == ST_LOCKED || state == ST_MANUAL;
        end
    end
endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: randomized serial-stream bench with a bit-level reference model
module tb_adc_frame_align;
    localparam int N_CH = 2, LPC = 4, NS = 4, SB = LPC*NS, NL = N_CH*LPC;
    localparam int D = 3, SETTLE = 3, LOCKN = 16;
    localparam logic [NS-1:0] FR = 4'b1100;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic [NL*NS-1:0] lane_data_in = '0;
    logic [NS-1:0] frame_data_in = '0;
    logic [N_CH*SB-1:0] sample_out;
    logic sample_valid_out, locked_out, fail_out;
    logic [NS-1:0] frame_out;
    logic [1:0] slip_out;
    logic [15:0] err_count_out;

    adc_frame_align_if bus();

    adc_frame_align dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cmd             (bus),
        .lane_data_in    (lane_data_in),
        .frame_data_in   (frame_data_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out),
        .frame_out       (frame_out),
        .locked_out      (locked_out),
        .fail_out        (fail_out),
        .slip_out        (slip_out),
        .err_count_out   (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [N_CH*SB-1:0] hist [1024];
    logic [NS-1:0] prev_tw [NL+1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // true words serialized MSB-first across lanes, then delayed by D bits on the wire
    task automatic step(input bit miss = 1'b0, input bit zero = 1'b0);
        logic [N_CH*SB-1:0] smp;
        logic [NS-1:0] tw;
        logic [2*NS-1:0] two;
        for (int c = 0; c < N_CH; c++) smp[c*SB +: SB] = SB'($urandom);
        for (int L = 0; L <= NL; L++) begin
            tw = '0;
            if (L == NL) tw = (miss || zero) ? '0 : FR;
            else for (int i = 0; i < SB; i++)
                if (i % LPC == L % LPC) tw[NS-1-i/LPC] = smp[(L/LPC)*SB + SB-1-i];
            two = {prev_tw[L], tw} >> D;
            if (L == NL) frame_data_in = two[NS-1:0];
            else lane_data_in[L*NS +: NS] = two[NS-1:0];
            prev_tw[L] = tw;
        end
        hist[cyc % 1024] = smp;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] d, input bit zero = 1'b0);
        bus.cmd_trig_in = 1'b1;
        bus.cmd_addr_in = a;
        bus.cmd_data_in = d;
        step(1'b0, zero);
        bus.cmd_trig_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_smp"}, sample_out, 0);
        check({tag, "_vld"}, sample_valid_out, 0);
        check({tag, "_frm"}, frame_out, 0);
        check({tag, "_lck"}, locked_out, 0);
        check({tag, "_fail"}, fail_out, 0);
        check({tag, "_slip"}, slip_out, 0);
        check({tag, "_err"}, err_count_out, 0);
    endtask

    task automatic wait_lock(input int bound);
        for (int t = 0; t < bound && !locked_out; t++) step();
        check("lock_wait", locked_out, 1);
    endtask

    initial begin
        int last_s, last_c, n_ch, dropped, wrap;
        logic [15:0] d;
        bus.cmd_trig_in = 1'b0;
        bus.cmd_addr_in = '0;
        bus.cmd_data_in = '0;
        for (int L = 0; L <= NL; L++) prev_tw[L] = '0;
        step();
        step();
        check_zero("rst");
        rst_in = 1'b0;

        last_s = 0; last_c = cyc; n_ch = 0;
        for (int t = 0; t < 200 && n_ch < 3; t++) begin
            step();
            if (int'(slip_out) != last_s) begin
                check("slip_val", slip_out, last_s + 1);
                check("slip_gap", cyc - last_c, SETTLE + 1);
                last_s = int'(slip_out); last_c = cyc; n_ch++;
            end
        end
        check("slip_steps", n_ch, 3);
        for (int t = 0; t < 100 && !locked_out; t++) step();
        check("lock_gap", cyc - last_c, SETTLE + LOCKN);
        check("lock_slip", slip_out, D);
        for (int t = 0; t < 6; t++) begin
            step();
            check("sample", sample_out, hist[(cyc - 3) % 1024]);
        end
        check("frame", frame_out, FR);
        check("valid", sample_valid_out, 1);

        for (int t = 0; t < 3; t++) step(1'b1);
        for (int t = 0; t < 4; t++) step();
        check("miss3_lck", locked_out, 1);
        check("miss3_err", err_count_out, 3);
        dropped = 0;
        for (int t = 0; t < 12; t++) begin
            step(t < 4);
            if (!locked_out) dropped = 1;
        end
        check("miss4_drop", dropped, 1);
        check("miss4_slip", slip_out, D);
        check("miss4_err", err_count_out, 7);
        wait_lock(60);
        check("relock_slip", slip_out, D);

        step(1'b1);
        step();
        send(16'h3302, 16'h0000);
        step();
        step();
        check("clr_err", err_count_out, 0);
        check("clr_lck", locked_out, 1);
        step(1'b1);
        step();
        step();
        send(16'h3202, 16'h0000);
        step();
        check("ign_clr", err_count_out, 1);
        send(16'h3200, 16'h0000);
        check("ign_rea_slip", slip_out, D);
        check("ign_rea_lck", locked_out, 1);
        send(16'h3303, 16'h0001);
        check("ign_sub_slip", slip_out, D);

        rst_in = 1'b1;
        step();
        check_zero("rst2");
        rst_in = 1'b0;
        wait_lock(200);
        check("rst_relock_slip", slip_out, D);

        last_s = int'(slip_out); n_ch = 0; wrap = 0;
        for (int t = 0; t < 300 && !fail_out; t++) begin
            step(1'b0, 1'b1);
            if (int'(slip_out) != last_s) begin
                if (last_s == NS - 1 && slip_out == 0) wrap = 1;
                last_s = int'(slip_out); n_ch++;
            end
        end
        check("fail_set", fail_out, 1);
        check("fail_steps", n_ch, 2*NS);
        check("fail_wrap", wrap, 1);
        send(16'h3300, 16'h0000, 1'b1);
        check("realign_fail", fail_out, 0);
        check("realign_slip", slip_out, 0);

        send(16'h3301, 16'h0002, 1'b1);
        check("man_slip", slip_out, 2);
        check("man_lck", locked_out, 0);
        for (int t = 0; t < 20; t++) step(1'b0, 1'b1);
        check("man_hold", slip_out, 2);
        check("man_vld", sample_valid_out, 1);
        check("man_lck2", locked_out, 0);
        d = 16'($urandom);
        send(16'h3301, d, 1'b1);
        check("man_mod", slip_out, d % 16'(NS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
